// File: rtl/tt_uio_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : tt_uio_bus_arbiter_if
//  Brief    : Requester handshake and uio pad bundle for the bus arbiter.
//             The slave modport is the arbiter's view; the master modport is
//             the view of the requesters and pads.
//  Revision : 1.0  initial release
// ============================================================================
interface tt_uio_bus_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   dir;
    logic [8*NREQ-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        rdata;
    logic              rvalid;
    logic              busy;
    logic [7:0]        uio_in;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;

    modport slave (
        input  req, dir, wdata, uio_in,
        output gnt, rdata, rvalid, busy, uio_out, uio_oe
    );

    modport master (
        output req, dir, wdata, uio_in,
        input  gnt, rdata, rvalid, busy, uio_out, uio_oe
    );
endinterface
`default_nettype wire

// File: rtl/tt_uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tt_uio_bus_arbiter
//  Brief    : Round-robin arbiter sharing the 8-bit bidirectional uio pad bus
//             between NREQ requesters, with a burst limit and a forced
//             tristate turnaround gap on every ownership change.
//  Revision : 1.0  initial release
// ============================================================================
module tt_uio_bus_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 4,
    parameter int TURN_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tt_uio_bus_arbiter_if.slave   bus
);

    localparam int IDX_W   = $clog2(NREQ);
    localparam int TCNT_W  = $clog2(TURN_CYC + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [TCNT_W-1:0]  c_TCNT_LAST  = TCNT_W'(TURN_CYC - 1);
    localparam logic [BURST_W-1:0] c_BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]   c_LAST_IDX   = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    logic               r_rst_i;
    state_t             r_state,    w_state_nxt;
    logic [IDX_W-1:0]   r_owner,    w_owner_nxt;
    logic               r_own_dir,  w_own_dir_nxt;
    logic [TCNT_W-1:0]  r_tcnt,     w_tcnt_nxt;
    logic [BURST_W-1:0] r_burst,    w_burst_nxt;
    logic [IDX_W-1:0]   r_rr_ptr,   w_rr_ptr_nxt;
    logic [NREQ-1:0]    r_gnt,      w_gnt_nxt;
    logic [7:0]         r_rdata;
    logic               r_rvalid;

    logic [NREQ-1:0]    w_owner_onehot;
    logic [NREQ-1:0]    w_req_oth;
    logic               w_owner_req;
    logic [IDX_W-1:0]   w_win_all;
    logic [IDX_W-1:0]   w_win_oth;
    logic               w_drive;

    // First set bit of mask, scanning upward from ptr with wrap-around.
    function automatic logic [IDX_W-1:0] f_pick(input logic [NREQ-1:0] mask,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && mask[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_owner_onehot = NREQ'(1) << r_owner;
    assign w_req_oth      = bus.req & ~w_owner_onehot;
    assign w_owner_req    = |(bus.req & w_owner_onehot);
    assign w_win_all      = f_pick(bus.req, r_rr_ptr);
    assign w_win_oth      = f_pick(w_req_oth, r_rr_ptr);

    // Reset release is held off one clock so deassertion is synchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_i <= 1'b0;
        else        r_rst_i <= 1'b1;
    end

    // Next-state and grant decisions; everything defaults to holding.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_own_dir_nxt = r_own_dir;
        w_tcnt_nxt    = r_tcnt;
        w_burst_nxt   = r_burst;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_gnt_nxt     = r_gnt;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_state_nxt   = ST_TURN;
                    w_owner_nxt   = w_win_all;
                    w_own_dir_nxt = bus.dir[w_win_all];
                    w_tcnt_nxt    = '0;
                end
            end
            ST_TURN: begin
                if (!w_owner_req) begin
                    // Candidate went away before its grant: pick again or park.
                    if (|bus.req) begin
                        w_owner_nxt   = w_win_all;
                        w_own_dir_nxt = bus.dir[w_win_all];
                        w_tcnt_nxt    = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_tcnt == c_TCNT_LAST) begin
                    w_state_nxt  = ST_GRANT;
                    w_gnt_nxt    = w_owner_onehot;
                    w_burst_nxt  = '0;
                    w_rr_ptr_nxt = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    // Owner release takes precedence over burst expiry.
                    w_gnt_nxt = '0;
                    if (|w_req_oth) begin
                        w_state_nxt   = ST_TURN;
                        w_owner_nxt   = w_win_oth;
                        w_own_dir_nxt = bus.dir[w_win_oth];
                        w_tcnt_nxt    = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if ((r_burst == c_BURST_LAST) && (|w_req_oth)) begin
                    w_gnt_nxt     = '0;
                    w_state_nxt   = ST_TURN;
                    w_owner_nxt   = w_win_oth;
                    w_own_dir_nxt = bus.dir[w_win_oth];
                    w_tcnt_nxt    = '0;
                end else if (r_burst != c_BURST_LAST) begin
                    w_burst_nxt = r_burst + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // Arbiter state registers; held cleared until internal reset releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_own_dir <= 1'b0;
            r_tcnt    <= '0;
            r_burst   <= '0;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
        end else if (!r_rst_i) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_own_dir <= 1'b0;
            r_tcnt    <= '0;
            r_burst   <= '0;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_own_dir <= w_own_dir_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_burst   <= w_burst_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
        end
    end

    // Pad sample for a read owner; rdata holds between read grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= 8'h00;
            r_rvalid <= 1'b0;
        end else if (!r_rst_i) begin
            r_rdata  <= 8'h00;
            r_rvalid <= 1'b0;
        end else if ((r_state == ST_GRANT) && !r_own_dir) begin
            r_rdata  <= bus.uio_in;
            r_rvalid <= 1'b1;
        end else begin
            r_rvalid <= 1'b0;
        end
    end

    // Pads decode straight from state so an async reset tristates at once.
    assign w_drive     = (r_state == ST_GRANT) && r_own_dir;
    assign bus.uio_oe  = w_drive ? 8'hFF : 8'h00;
    assign bus.uio_out = w_drive ? bus.wdata[int'(r_owner)*8 +: 8] : 8'h00;
    assign bus.gnt     = r_gnt;
    assign bus.rdata   = r_rdata;
    assign bus.rvalid  = r_rvalid;
    assign bus.busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire
